rf_arbiter: RTL and testbench

Controller that owns the register file's single write port and read port B, sharing them between the CPU core and a debug requester. When configured, it also zeroes all 32 registers after reset. It sits between the core/debug logic and the register file; read port A is a straight pass-through from the core.

---
 rtl/rf_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter.sv
`default_nettype none
// ============================================================================
// rf_arbiter: shares the register-file write port and read port B between the
// CPU core and a debug requester; optional post-reset zero sweep.
// Optional feature macro: RF_CLEAR_ON_RESET_EN (enables CLEAR state / sweep)
// Revision: 1.0
// ============================================================================
module rf_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_w_valid,
  input  logic [4:0]  core_w_addr,
  input  logic [31:0] core_w_data,
  output logic        core_w_ready,
  input  logic [4:0]  core_ra_addr,
  input  logic [4:0]  core_rb_addr,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        busy,
  output logic [31:0] rf_w_data,
  output logic [4:0]  rf_w_addr,
  output logic        rf_w_ena,
  output logic [4:0]  rf_ra_addr,
  output logic [4:0]  rf_rb_addr,
  input  logic [31:0] rf_ra_data,
  input  logic [31:0] rf_rb_data
);

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    DBG_RD  = 3'd2,
    DBG_CAP = 3'd3,
    DBG_ACK = 3'd4
  } state_t;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t     state;
  state_t     state_nxt;
  logic [1:0] starve_cnt;
  logic [1:0] starve_nxt;
  logic       dbg_wr_pend;

  // Port A read data goes to the core directly; only the address passes here.
  logic unused_ra_data;
  assign unused_ra_data = ^rf_ra_data;

  assign rf_ra_addr  = core_ra_addr;
  assign dbg_wr_pend = dbg_req & dbg_we;

`ifdef RF_CLEAR_ON_RESET_EN
  logic [4:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= 5'd0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 5'd1;
    end
  end

  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    starve_nxt   = starve_cnt;
    core_w_ready = 1'b1;
    core_stall   = 1'b0;
    rf_w_ena     = core_w_valid && (core_w_addr != 5'd0);
    rf_w_addr    = core_w_addr;
    rf_w_data    = core_w_data;
    rf_rb_addr   = core_rb_addr;
    case (state)
`ifdef RF_CLEAR_ON_RESET_EN
      CLEAR: begin
        core_w_ready = 1'b0;
        core_stall   = 1'b1;
        rf_w_ena     = 1'b1;
        rf_w_addr    = clr_cnt;
        rf_w_data    = 32'd0;
        if (clr_cnt == 5'd31) begin
          state_nxt = IDLE;
        end
      end
`endif
      IDLE: begin
        // Debug write takes the port when the core is quiet or has won 3 times.
        if (dbg_wr_pend && (!core_w_valid || starve_cnt == 2'd3)) begin
          core_w_ready = 1'b0;
          rf_w_ena     = (dbg_addr != 5'd0);
          rf_w_addr    = dbg_addr;
          rf_w_data    = dbg_wdata;
          starve_nxt   = 2'd0;
          state_nxt    = DBG_ACK;
        end else begin
          if (dbg_wr_pend && core_w_valid && starve_cnt != 2'd3) begin
            starve_nxt = starve_cnt + 2'd1;
          end
          if (dbg_req && !dbg_we) begin
            state_nxt = DBG_RD;
          end
        end
      end
      DBG_RD: begin
        core_stall = 1'b1;
        rf_rb_addr = dbg_addr;
        state_nxt  = DBG_CAP;
      end
      DBG_CAP: begin
        core_stall = 1'b1;
        state_nxt  = DBG_ACK;
      end
      DBG_ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_STATE;
      starve_cnt <= 2'd0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= 32'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      dbg_ack    <= (state_nxt == DBG_ACK);
      if (state == DBG_CAP) begin
        dbg_rdata <= rf_rb_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_arbiter: randomized self-checking bench with a register-file model and
// an array-based reference of expected register contents.
// Revision: 1.0
// ============================================================================
module tb_rf_arbiter;

  logic        clk;
  logic        rst_n;
  logic        core_w_valid;
  logic [4:0]  core_w_addr;
  logic [31:0] core_w_data;
  logic        core_w_ready;
  logic [4:0]  core_ra_addr;
  logic [4:0]  core_rb_addr;
  logic        core_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        busy;
  logic [31:0] rf_w_data;
  logic [4:0]  rf_w_addr;
  logic        rf_w_ena;
  logic [4:0]  rf_ra_addr;
  logic [4:0]  rf_rb_addr;
  logic [31:0] rf_ra_data;
  logic [31:0] rf_rb_data;

  logic        rf_scramble;
  logic [31:0] rf_mem  [32];
  logic [31:0] exp_mem [32];
  bit          exp_known [32];
  int          checks = 0;
  int          errors = 0;

  rf_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_w_valid(core_w_valid), .core_w_addr(core_w_addr), .core_w_data(core_w_data),
    .core_w_ready(core_w_ready), .core_ra_addr(core_ra_addr), .core_rb_addr(core_rb_addr),
    .core_stall(core_stall), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .busy(busy),
    .rf_w_data(rf_w_data), .rf_w_addr(rf_w_addr), .rf_w_ena(rf_w_ena),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous reads with write-through, garbage fill on demand.
  always @(posedge clk) begin
    if (rf_scramble) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (rf_w_ena) begin
      rf_mem[rf_w_addr] <= rf_w_data;
    end
    rf_ra_data <= (rf_w_ena && rf_w_addr == rf_ra_addr) ? rf_w_data : rf_mem[rf_ra_addr];
    rf_rb_data <= (rf_w_ena && rf_w_addr == rf_rb_addr) ? rf_w_data : rf_mem[rf_rb_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_w_valid = 1'b0; core_w_addr = 5'd0; core_w_data = 32'd0;
    core_ra_addr = 5'd0; core_rb_addr = 5'd0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
  endtask

  task automatic model_wr(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      exp_mem[a]   = d;
      exp_known[a] = 1'b1;
    end
  endtask

  task automatic rand_core(input bit active);
    core_w_valid = active ? 1'($urandom_range(0, 1)) : 1'b0;
    core_w_addr  = 5'($urandom_range(0, 31));
    core_w_data  = $urandom();
    core_ra_addr = 5'($urandom_range(0, 31));
    core_rb_addr = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); rf_scramble = 1'b1;
    for (int i = 0; i < 32; i++) exp_known[i] = 1'b0;
    tick(); tick();
    rf_scramble = 1'b0;
    #1;
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b exp 0", dbg_ack); end
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
`ifdef RF_CLEAR_ON_RESET_EN
    checks++; if (busy !== 1'b1 || core_w_ready !== 1'b0) begin
      errors++; $display("FAIL reset_busy busy=%0b ready=%0b exp busy=1 ready=0", busy, core_w_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (busy !== 1'b1 || rf_w_ena !== 1'b1 || rf_w_addr !== 5'(i) || rf_w_data !== 32'd0 ||
          core_stall !== 1'b1 || core_w_ready !== 1'b0) begin
        errors++;
        $display("FAIL sweep_%0d busy=%0b ena=%0b addr=%0d data=%h stall=%0b ready=%0b exp 1 1 %0d 0 1 0",
                 i, busy, rf_w_ena, rf_w_addr, rf_w_data, core_stall, core_w_ready, i);
      end
      tick(); #1;
    end
    checks++; if (busy !== 1'b0 || core_w_ready !== 1'b1 || core_stall !== 1'b0) begin
      errors++; $display("FAIL sweep_done busy=%0b ready=%0b stall=%0b exp 0 1 0", busy, core_w_ready, core_stall);
    end
    for (int i = 0; i < 32; i++) begin exp_mem[i] = 32'd0; exp_known[i] = 1'b1; end
    for (int i = 0; i < 32; i++) begin
      core_ra_addr = 5'(i);
      tick();
      checks++; if (rf_ra_data !== 32'd0) begin errors++; $display("FAIL clear_read x%0d got %h exp 0", i, rf_ra_data); end
    end
`else
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    rst_n = 1'b1;
    core_w_valid = 1'b1; core_w_addr = 5'd3; core_w_data = $urandom();
    #1;
    checks++; if (core_w_ready !== 1'b1 || rf_w_ena !== 1'b1 || rf_w_addr !== 5'd3) begin
      errors++; $display("FAIL first_write ready=%0b ena=%0b addr=%0d exp 1 1 3", core_w_ready, rf_w_ena, rf_w_addr);
    end
    tick(); model_wr(core_w_addr, core_w_data);
    for (int i = 1; i < 32; i++) begin
      core_w_addr = 5'(i); core_w_data = $urandom();
      tick(); model_wr(core_w_addr, core_w_data);
    end
    core_w_valid = 1'b0; core_ra_addr = 5'd3;
    tick();
    checks++; if (rf_ra_data !== exp_mem[3]) begin errors++; $display("FAIL first_read got %h exp %h", rf_ra_data, exp_mem[3]); end
`endif
    idle_inputs();
  endtask

  task automatic test_core_write();
    logic [4:0] ra, rb, wa; logic [31:0] wd; logic wv;
    core_w_valid = 1'b1; core_w_addr = 5'd5; core_w_data = 32'hDEADBEEF;
    #1;
    checks++; if (rf_w_ena !== 1'b1 || rf_w_addr !== 5'd5 || rf_w_data !== 32'hDEADBEEF || core_w_ready !== 1'b1) begin
      errors++; $display("FAIL wr_x5 ena=%0b addr=%0d data=%h ready=%0b exp 1 5 deadbeef 1", rf_w_ena, rf_w_addr, rf_w_data, core_w_ready);
    end
    tick(); model_wr(5'd5, 32'hDEADBEEF);
    core_w_valid = 1'b0; core_ra_addr = 5'd5;
    tick();
    checks++; if (rf_ra_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_x5 got %h exp deadbeef", rf_ra_data); end
    core_w_valid = 1'b1; core_w_addr = 5'd0; core_w_data = $urandom();
    #1;
    checks++; if (rf_w_ena !== 1'b0 || core_w_ready !== 1'b1) begin
      errors++; $display("FAIL wr_x0 ena=%0b ready=%0b exp 0 1", rf_w_ena, core_w_ready);
    end
    tick();
    for (int n = 0; n < 24; n++) begin
      wv = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31)); wd = $urandom();
      ra = 5'($urandom_range(0, 31)); rb = 5'($urandom_range(0, 31));
      core_w_valid = wv; core_w_addr = wa; core_w_data = wd; core_ra_addr = ra; core_rb_addr = rb;
      #1;
      checks++;
      if (rf_ra_addr !== ra || rf_rb_addr !== rb || rf_w_ena !== (wv && wa != 5'd0) || core_w_ready !== 1'b1 ||
          core_stall !== 1'b0 || (wv && (rf_w_addr !== wa || rf_w_data !== wd))) begin
        errors++;
        $display("FAIL core_rand%0d ra=%0d rb=%0d ena=%0b waddr=%0d wdata=%h ready=%0b stall=%0b exp %0d %0d %0b %0d %h 1 0",
                 n, rf_ra_addr, rf_rb_addr, rf_w_ena, rf_w_addr, rf_w_data, core_w_ready, core_stall,
                 ra, rb, (wv && wa != 5'd0), wa, wd);
      end
      tick();
      if (wv) model_wr(wa, wd);
      if (exp_known[ra]) begin
        checks++; if (rf_ra_data !== exp_mem[ra]) begin errors++; $display("FAIL core_rda%0d got %h exp %h", n, rf_ra_data, exp_mem[ra]); end
      end
      if (exp_known[rb]) begin
        checks++; if (rf_rb_data !== exp_mem[rb]) begin errors++; $display("FAIL core_rdb%0d got %h exp %h", n, rf_rb_data, exp_mem[rb]); end
      end
    end
    idle_inputs();
  endtask

  task automatic do_read(input logic [4:0] a, input bit core_active, input bit force_wt);
    logic [31:0] snap; bit known;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
    rand_core(core_active);
    #1;
    checks++; if (core_stall !== 1'b0 || core_w_ready !== 1'b1 || rf_rb_addr !== core_rb_addr) begin
      errors++; $display("FAIL rd_req stall=%0b ready=%0b rb=%0d exp 0 1 %0d", core_stall, core_w_ready, rf_rb_addr, core_rb_addr);
    end
    tick(); if (core_w_valid) model_wr(core_w_addr, core_w_data);
    rand_core(core_active);
    if (force_wt) begin core_w_valid = 1'b1; core_w_addr = a; core_w_data = $urandom(); end
    #1;
    checks++;
    if (core_stall !== 1'b1 || rf_rb_addr !== a || core_w_ready !== 1'b1 || dbg_ack !== 1'b0 ||
        rf_w_ena !== (core_w_valid && core_w_addr != 5'd0)) begin
      errors++; $display("FAIL rd_rd stall=%0b rb=%0d ready=%0b ack=%0b ena=%0b exp 1 %0d 1 0 %0b",
                         core_stall, rf_rb_addr, core_w_ready, dbg_ack, rf_w_ena, a, (core_w_valid && core_w_addr != 5'd0));
    end
    tick(); if (core_w_valid) model_wr(core_w_addr, core_w_data);
    snap = exp_mem[a]; known = exp_known[a];
    rand_core(core_active);
    #1;
    checks++; if (core_stall !== 1'b1 || dbg_ack !== 1'b0 || rf_rb_addr !== core_rb_addr) begin
      errors++; $display("FAIL rd_cap stall=%0b ack=%0b rb=%0d exp 1 0 %0d", core_stall, dbg_ack, rf_rb_addr, core_rb_addr);
    end
    tick(); if (core_w_valid) model_wr(core_w_addr, core_w_data);
    rand_core(core_active);
    #1;
    checks++; if (dbg_ack !== 1'b1 || core_stall !== 1'b0) begin
      errors++; $display("FAIL rd_ack ack=%0b stall=%0b exp 1 0", dbg_ack, core_stall);
    end
    if (known) begin
      checks++; if (dbg_rdata !== snap) begin errors++; $display("FAIL rd_data x%0d got %h exp %h", a, dbg_rdata, snap); end
    end
    dbg_req = 1'b0;
    tick(); if (core_w_valid) model_wr(core_w_addr, core_w_data);
    core_w_valid = 1'b0;
    #1;
    checks++; if (dbg_ack !== 1'b0 || (known && dbg_rdata !== snap)) begin
      errors++; $display("FAIL rd_hold ack=%0b data=%h exp 0 %h", dbg_ack, dbg_rdata, snap);
    end
    idle_inputs();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input bit hold);
    int lost; bit issued; bit exp_win;
    lost = 0; issued = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    for (int c = 0; c < 8 && !issued; c++) begin
      rand_core(1'b1);
      if (hold) core_w_valid = 1'b1;
      if (core_w_addr == a) core_w_addr = core_w_addr ^ 5'd1;
      #1;
      exp_win = !core_w_valid || lost == 3;
      checks++; if (core_w_ready !== !exp_win) begin
        errors++; $display("FAIL wr_ready cyc%0d got %0b exp %0b", c, core_w_ready, !exp_win);
      end
      if (exp_win) begin
        checks++; if (rf_w_addr !== a || rf_w_data !== d || rf_w_ena !== (a != 5'd0)) begin
          errors++; $display("FAIL wr_issue addr=%0d data=%h ena=%0b exp %0d %h %0b", rf_w_addr, rf_w_data, rf_w_ena, a, d, (a != 5'd0));
        end
      end
      tick();
      if (exp_win) begin
        model_wr(a, d); issued = 1'b1;
      end else begin
        model_wr(core_w_addr, core_w_data); lost++;
      end
    end
    rand_core(1'b1);
    if (core_w_addr == a) core_w_addr = core_w_addr ^ 5'd1;
    #1;
    checks++; if (dbg_ack !== 1'b1 || core_w_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ack ack=%0b ready=%0b exp 1 1", dbg_ack, core_w_ready);
    end
    dbg_req = 1'b0;
    tick(); if (core_w_valid) model_wr(core_w_addr, core_w_data);
    core_w_valid = 1'b0; core_ra_addr = a;
    tick();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_len got %0b exp 0", dbg_ack); end
    if (exp_known[a]) begin
      checks++; if (rf_ra_data !== exp_mem[a]) begin errors++; $display("FAIL wr_readback x%0d got %h exp %h", a, rf_ra_data, exp_mem[a]); end
    end
    idle_inputs();
  endtask

  task automatic test_dbg_read();
    core_w_valid = 1'b1; core_w_addr = 5'd5; core_w_data = 32'hDEADBEEF;
    tick(); model_wr(5'd5, 32'hDEADBEEF);
    idle_inputs();
    do_read(5'd5, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) do_read(5'($urandom_range(0, 31)), 1'b1, 1'(n % 2));
  endtask

  task automatic test_dbg_write();
    do_write(5'd7, 32'h12345678, 1'b1);
    do_write(5'd0, $urandom(), 1'b0);
    for (int n = 0; n < 6; n++) do_write(5'($urandom_range(1, 31)), $urandom(), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)));
      else do_read(5'($urandom_range(0, 31)), 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_abort();
    core_w_valid = 1'b1; core_w_addr = 5'd5; core_w_data = 32'hDEADBEEF;
    tick(); model_wr(5'd5, 32'hDEADBEEF);
    idle_inputs();
    do_read(5'd5, 1'b0, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_ack !== 1'b0 || dbg_rdata !== 32'd0) begin
      errors++; $display("FAIL abort_reset ack=%0b data=%h exp 0 0", dbg_ack, dbg_rdata);
    end
    rst_n = 1'b1;
`ifdef RF_CLEAR_ON_RESET_EN
    for (int i = 0; i < 32; i++) begin
      checks++; if (busy !== 1'b1 || rf_w_addr !== 5'(i) || rf_w_data !== 32'd0 || dbg_ack !== 1'b0) begin
        errors++; $display("FAIL abort_sweep_%0d busy=%0b addr=%0d data=%h ack=%0b exp 1 %0d 0 0", i, busy, rf_w_addr, rf_w_data, dbg_ack, i);
      end
      tick(); #1;
    end
    for (int i = 0; i < 32; i++) begin exp_mem[i] = 32'd0; exp_known[i] = 1'b1; end
`endif
    checks++; if (busy !== 1'b0 || core_stall !== 1'b0 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL abort_idle busy=%0b stall=%0b ack=%0b exp 0 0 0", busy, core_stall, dbg_ack);
    end
    tick();
    checks++; if (core_stall !== 1'b1 || dbg_ack !== 1'b0) begin errors++; $display("FAIL abort_rd stall=%0b ack=%0b exp 1 0", core_stall, dbg_ack); end
    tick();
    checks++; if (core_stall !== 1'b1 || dbg_ack !== 1'b0) begin errors++; $display("FAIL abort_cap stall=%0b ack=%0b exp 1 0", core_stall, dbg_ack); end
    tick();
    checks++; if (dbg_ack !== 1'b1 || dbg_rdata !== exp_mem[5]) begin
      errors++; $display("FAIL abort_retry ack=%0b data=%h exp 1 %h", dbg_ack, dbg_rdata, exp_mem[5]);
    end
    dbg_req = 1'b0;
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_dbg_read();
    test_dbg_write();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
